dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 16-bit data memory between the processor's load/store path (port 0) and a host/loader port (port 1). Each port uses a request/acknowledge handshake. The arbiter serialises accesses onto one RAM interface with registered address, data and control. The RAM has 1-cycle read latency. The arbiter sits between the processor datapath and the `dataMem` array, which becomes an external synchronous-read RAM.

---
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port request/ack arbiter that shares a single-port synchronous-read RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; the default build uses fixed port-0 priority.
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              owner,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            state_q;
  logic              owner_q, ram_en_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic              lg_q;
`endif

  logic              gnt_vld_d, gnt_port_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              resp;

  // In RESP the owner is masked: it is being acked and may still hold req.
  always_comb begin
    gnt_vld_d  = 1'b0;
    gnt_port_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 && req1) begin
          gnt_vld_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          gnt_port_d = ~lg_q;
`else
          gnt_port_d = 1'b0;
`endif
        end else if (req0) begin
          gnt_vld_d  = 1'b1;
          gnt_port_d = 1'b0;
        end else if (req1) begin
          gnt_vld_d  = 1'b1;
          gnt_port_d = 1'b1;
        end
      end
      S_RESP: begin
        gnt_vld_d  = owner_q ? req0 : req1;
        gnt_port_d = ~owner_q;
      end
      default: ;
    endcase
  end

  assign sel_we    = gnt_port_d ? we1    : we0;
  assign sel_addr  = gnt_port_d ? addr1  : addr0;
  assign sel_wdata = gnt_port_d ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lg_q        <= 1'b1;
`endif
    end else if (gnt_vld_d) begin
      state_q     <= S_ACCESS;
      owner_q     <= gnt_port_d;
      ram_en_q    <= 1'b1;
      ram_we_q    <= sel_we;
      ram_addr_q  <= sel_addr;
      ram_wdata_q <= sel_wdata;
`ifdef ARB_ROUND_ROBIN_EN
      lg_q        <= gnt_port_d;
`endif
    end else begin
      state_q  <= (state_q == S_ACCESS) ? S_RESP : S_IDLE;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
    end
  end

  assign resp      = (state_q == S_RESP);
  assign ack0      = resp & ~owner_q;
  assign ack1      = resp &  owner_q;
  assign rdata0    = ack0 ? ram_rdata : '0;
  assign rdata1    = ack1 ? ram_rdata : '0;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 128x16 synchronous-read RAM.
module tb_dmem_arbiter;
  logic        clk, rst;
  logic        req0, req1, we0, we1;
  logic [6:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, busy, owner, ram_en, ram_we;
  logic [15:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [6:0]  ram_addr;
  logic [15:0] mem [128];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .owner(owner), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},   busy,      0);
    chk({tag, "_owner"},  owner,     0);
    chk({tag, "_ram_en"}, ram_en,    0);
    chk({tag, "_ram_we"}, ram_we,    0);
    chk({tag, "_addr"},   ram_addr,  0);
    chk({tag, "_wdata"},  ram_wdata, 0);
    chk({tag, "_ack0"},   ack0,      0);
    chk({tag, "_ack1"},   ack1,      0);
    chk({tag, "_rdata0"}, rdata0,    0);
    chk({tag, "_rdata1"}, rdata1,    0);
  endtask

  // Single access from IDLE; ack is expected exactly 2 edges after req is raised.
  task automatic access(input bit p, input logic w, input logic [6:0] a,
                        input logic [15:0] d, output logic [15:0] rd);
    int   cyc;
    logic got;
    if (!p) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else    begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 8) begin
      step();
      cyc++;
      got = p ? ack1 : ack0;
      chk("other_ack_low", p ? ack0 : ack1, 0);
    end
    chk("ack_latency", cyc, 2);
    rd = p ? rdata1 : rdata0;
    chk("other_rdata_zero", p ? rdata0 : rdata1, 0);
    if (!p) req0 = 1'b0; else req1 = 1'b0;
    step();
    chk("busy_after_access", busy, 0);
  endtask

  initial begin
    logic [15:0] rd;
    int n_ack, last;
    rst = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    step(); step();
    chk_reset("rst0");
    rst = 1'b1;
    step();

    // Port 0 write then read-back
    access(1'b0, 1'b1, 7'd5, 16'h1234, rd);
    access(1'b0, 1'b0, 7'd5, 16'h0000, rd);
    chk("t1_rdata0", rd, 16'h1234);

    // Preload through port 1, then reset so the next test starts fresh
    access(1'b1, 1'b1, 7'd3, 16'hAAAA, rd);
    access(1'b1, 1'b1, 7'd4, 16'h5555, rd);
    rst = 1'b0;
    step();
    chk_reset("rst1");
    rst = 1'b1;
    step();

    // Simultaneous requests: port 0 first, port 1 back-to-back
    we0 = 0; addr0 = 7'd3; we1 = 0; addr1 = 7'd4;
    req0 = 1; req1 = 1;
    step();
    chk("t2_busy", busy, 1);
    chk("t2_owner0", owner, 0);
    chk("t2_addr0", ram_addr, 3);
    chk("t2_en", ram_en, 1);
    step();
    chk("t2_ack0", ack0, 1);
    chk("t2_rdata0", rdata0, 16'hAAAA);
    chk("t2_ack1_low", ack1, 0);
    chk("t2_rdata1_zero", rdata1, 0);
    req0 = 0;
    step();
    chk("t2_b2b_busy", busy, 1);
    chk("t2_owner1", owner, 1);
    chk("t2_addr1", ram_addr, 4);
    chk("t2_no_ack", {ack0, ack1}, 0);
    step();
    chk("t2_ack1", ack1, 1);
    chk("t2_rdata1", rdata1, 16'h5555);
    chk("t2_rdata0_zero", rdata0, 0);
    req1 = 0;
    step();
    chk("t2_idle", busy, 0);

    // Both ports held continuously: acks alternate every 2 cycles
    we0 = 0; addr0 = 7'd3; we1 = 0; addr1 = 7'd4;
    req0 = 1; req1 = 1;
    n_ack = 0;
    last = 0;
    for (int c = 0; c < 40 && n_ack < 8; c++) begin
      step();
      chk("t3_no_dual_ack", ack0 & ack1, 0);
      if (ack0 || ack1) begin
        chk("t3_port", ack1, n_ack % 2);
        chk("t3_rdata", ack1 ? rdata1 : rdata0, (n_ack % 2) ? 16'h5555 : 16'hAAAA);
        if (n_ack > 0) chk("t3_spacing", c - last, 2);
        last = c;
        n_ack++;
      end
    end
    req0 = 0; req1 = 0;
    chk("t3_count", n_ack, 8);
    step();
    chk("t3_idle", busy, 0);

    // Cross-port RAW: port 1 writes, port 0 reads in the back-to-back slot
    we1 = 1; addr1 = 7'd127; wdata1 = 16'hBEEF; req1 = 1;
    step();
    chk("t4_owner1", owner, 1);
    chk("t4_we", ram_we, 1);
    we0 = 0; addr0 = 7'd127; req0 = 1;
    step();
    chk("t4_ack1", ack1, 1);
    req1 = 0;
    step();
    chk("t4_owner0", owner, 0);
    chk("t4_raddr", ram_addr, 127);
    chk("t4_rd_we", ram_we, 0);
    step();
    chk("t4_ack0", ack0, 1);
    chk("t4_rdata0", rdata0, 16'hBEEF);
    req0 = 0;
    step();
    chk("t4_idle", busy, 0);

    // Reset during the ACCESS of a port-1 write
    we1 = 1; addr1 = 7'd10; wdata1 = 16'h1111; req1 = 1;
    step();
    chk("t5_access_we", ram_we, 1);
    chk("t5_access_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_we", ram_we, 0);
    chk("t5_async_busy", busy, 0);
    req1 = 0;
    step();
    chk("t5_no_ack1", ack1, 0);
    step();
    chk_reset("t5_in_rst");
    rst = 1'b1;
    step();
    chk("t5_post_ack1", ack1, 0);
    chk_reset("t5_post");

    // Idle quiescence
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_ram_en", ram_en, 0);
      chk("t6_busy", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
